// File: rtl/aes_bus_master.sv
// aes_bus_master: drives the AES-128 peripheral bus with eight key/plaintext writes,
// a fixed encrypt wait, then four ciphertext reads with a configurable read latency.
module aes_bus_master #(
   parameter int WAIT_CYCLES  = 24,
   parameter int READ_LATENCY = 1
) (
   input  logic         iClk,
   input  logic         iReset,
   input  logic         iStart,
   input  logic [127:0] iKey,
   input  logic [127:0] iPlain,
   output logic         oBusy,
   output logic         oDone,
   output logic [127:0] oCipher,
   output logic         oChipselect_n,
   output logic         oWrite_n,
   output logic         oRead_n,
   output logic [3:0]   oAddress,
   output logic [31:0]  oWrData,
   input  logic [31:0]  iRdData
);
   typedef enum logic [1:0] {IDLE, WRITE, WAIT, READ} state_t;
   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [7:0][31:0] data_q, data_d;
   logic [95:0]     rd_q, rd_d;
   logic [127:0]    cipher_q, cipher_d;
   logic            done_q, done_d;
   logic            cs_n_q, cs_n_d, we_n_q, we_n_d, re_n_q, re_n_d;
   logic [3:0]      addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;

   always_ff @(posedge iClk or posedge iReset)
      if (iReset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         data_q   <= '0;
         rd_q     <= '0;
         cipher_q <= '0;
         done_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
         re_n_q   <= 1'b1;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         rd_q     <= rd_d;
         cipher_q <= cipher_d;
         done_q   <= done_d;
         cs_n_q   <= cs_n_d;
         we_n_q   <= we_n_d;
         re_n_q   <= re_n_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      rd_d     = rd_q;
      cipher_d = cipher_q;
      done_d   = 1'b0;
      cs_n_d   = 1'b1;
      we_n_d   = 1'b1;
      re_n_d   = 1'b1;
      addr_d   = '0;
      wdata_d  = '0;
      case (state_q)
         IDLE:
            if (iStart) begin
               data_d  = {iKey, iPlain};
               cnt_d   = '0;
               state_d = WRITE;
            end
         WRITE: begin
            cs_n_d  = 1'b0;
            we_n_d  = 1'b0;
            addr_d  = cnt_q[3:0];
            wdata_d = data_q[3'd7 - cnt_q[2:0]];
            cnt_d   = cnt_q == 8'd7 ? '0 : cnt_q + 8'd1;
            state_d = cnt_q == 8'd7 ? WAIT : WRITE;
         end
         WAIT: begin
            cnt_d   = cnt_q == 8'(WAIT_CYCLES - 1) ? '0 : cnt_q + 8'd1;
            state_d = cnt_q == 8'(WAIT_CYCLES - 1) ? READ : WAIT;
         end
         READ: begin
            cs_n_d = cnt_q >= 8'd4;
            re_n_d = cnt_q >= 8'd4;
            addr_d = cnt_q < 8'd4 ? {2'b10, cnt_q[1:0]} : 4'd0;
            cnt_d  = cnt_q + 8'd1;
            // words arrive in address order, so shifting leaves word 0 on top
            if (cnt_q == 8'(READ_LATENCY + 3)) begin
               cipher_d = {rd_q, iRdData};
               done_d   = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end else if (cnt_q >= 8'(READ_LATENCY))
               rd_d = {rd_q[63:0], iRdData};
         end
         default: state_d = IDLE;
      endcase
   end

   assign oBusy         = state_q != IDLE;
   assign oDone         = done_q;
   assign oCipher       = cipher_q;
   assign oChipselect_n = cs_n_q;
   assign oWrite_n      = we_n_q;
   assign oRead_n       = re_n_q;
   assign oAddress      = addr_q;
   assign oWrData       = wdata_q;
endmodule

// File: tb/tb_aes_bus_master.sv
// tb_aes_bus_master: two masters (default timing and slow-read timing) each talking to a
// bus-level peripheral model; results checked against a transaction-level reference.
module tb_aes_bus_master;
   localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;

   logic          clk = 0, rst = 1;
   logic          st [2];
   logic [127:0]  key [2], pl [2], ciph [2];
   logic          busy [2], done [2], cs [2], we [2], re [2];
   logic [3:0]    addr [2];
   logic [31:0]   wd [2];
   logic [31:0]   rdat_a, rdat_b = 0;
   int            checks = 0, failures = 0, cyc = 0, s_edge = 0, done_edge = 0;
   logic [35:0]   wq [$], trace1 [$];
   int            rc [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_bus_master dut_a (
      .iClk(clk), .iReset(rst), .iStart(st[0]), .iKey(key[0]), .iPlain(pl[0]),
      .oBusy(busy[0]), .oDone(done[0]), .oCipher(ciph[0]), .oChipselect_n(cs[0]),
      .oWrite_n(we[0]), .oRead_n(re[0]), .oAddress(addr[0]), .oWrData(wd[0]), .iRdData(rdat_a));

   aes_bus_master #(.WAIT_CYCLES(30), .READ_LATENCY(2)) dut_b (
      .iClk(clk), .iReset(rst), .iStart(st[1]), .iKey(key[1]), .iPlain(pl[1]),
      .oBusy(busy[1]), .oDone(done[1]), .oCipher(ciph[1]), .oChipselect_n(cs[1]),
      .oWrite_n(we[1]), .oRead_n(re[1]), .oAddress(addr[1]), .oWrData(wd[1]), .iRdData(rdat_b));

   function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
      if (k == C1K && p == C1P) return C1C;
      if (k == BK && p == BP) return BC;
      return k ^ {p[95:0], p[127:96]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   endfunction

   function automatic logic [31:0] wsel(input logic [127:0] v, input logic [3:0] a);
      return 32'(v >> (32 * (3 - int'(a[1:0]))));
   endfunction

   // Peripheral models: result becomes readable only after the encrypt latency.
   logic [31:0]  pm_a [8], pm_b [8];
   logic [127:0] pres_a = 0, pres_b = 0;
   int           pcnt_a = 1000, pcnt_b = 1000;

   always @(posedge clk) begin
      pcnt_a <= pcnt_a + 1;
      if (!cs[0] && !we[0]) begin
         pm_a[addr[0][2:0]] <= wd[0];
         if (addr[0] == 4'd7) begin
            pres_a <= aes_ref({pm_a[0], pm_a[1], pm_a[2], pm_a[3]}, {pm_a[4], pm_a[5], pm_a[6], wd[0]});
            pcnt_a <= 0;
         end
      end
   end
   assign rdat_a = (!cs[0] && !re[0]) ? (pcnt_a >= 24 ? wsel(pres_a, addr[0]) : 32'hdeadbeef) : 32'h0;

   always @(posedge clk) begin
      pcnt_b <= pcnt_b + 1;
      if (!cs[1] && !we[1]) begin
         pm_b[addr[1][2:0]] <= wd[1];
         if (addr[1] == 4'd7) begin
            pres_b <= aes_ref({pm_b[0], pm_b[1], pm_b[2], pm_b[3]}, {pm_b[4], pm_b[5], pm_b[6], wd[1]});
            pcnt_b <= 0;
         end
      end
      rdat_b <= (!cs[1] && !re[1]) ? (pcnt_b >= 30 ? wsel(pres_b, addr[1]) : 32'hdeadbeef) : 32'h0;
   end

   // Protocol checker on both masters, plus bus trace capture.
   initial begin
      int nw [2], nr [2];
      bit dp [2];
      for (int d = 0; d < 2; d++) begin nw[d] = 0; nr[d] = 0; dp[d] = 0; end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!we[d] && !re[d]) begin failures++; $display("FAIL proto_strobes dut%0d: we=%b re=%b, not both 0", d, we[d], re[d]); end
            if (cs[d] && !(we[d] && re[d])) begin failures++; $display("FAIL proto_cs dut%0d: cs=%b we=%b re=%b, strobes must be 1", d, cs[d], we[d], re[d]); end
            if (cs[d] && (addr[d] !== 0 || wd[d] !== 0)) begin failures++; $display("FAIL proto_idle dut%0d: addr=%h wd=%h, required 0", d, addr[d], wd[d]); end
            if (done[d] && dp[d]) begin failures++; $display("FAIL proto_done_width dut%0d: done high 2 cycles", d); end
            dp[d] = done[d];
            if (rst) begin nw[d] = 0; nr[d] = 0; end
            else begin
               if (!cs[d] && !we[d]) nw[d]++;
               if (!cs[d] && !re[d]) nr[d]++;
               if (done[d]) begin
                  checks++;
                  if (nw[d] != 8 || nr[d] != 4) begin failures++; $display("FAIL proto_count dut%0d: writes=%0d reads=%0d, required 8/4", d, nw[d], nr[d]); end
                  nw[d] = 0; nr[d] = 0;
               end
            end
         end
         if (!cs[0] && !we[0]) wq.push_back({addr[0], wd[0]});
         if (!cs[1] && !re[1]) rc.push_back(cyc);
      end
   end

   task automatic start_op(input int d, input logic [127:0] k, input logic [127:0] p);
      key[d] = k; pl[d] = p; st[d] = 1;
      wq.delete(); rc.delete();
      @(posedge clk); #1 s_edge = cyc;
      @(negedge clk);
      st[d] = 0;
      key[d] = {$urandom, $urandom, $urandom, $urandom};
      pl[d] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_done(input int d, output int lat);
      lat = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done[d]) begin lat = cyc - s_edge; done_edge = cyc; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({busy[d], done[d], cs[d], we[d], re[d]} !== 5'b00111) begin failures++; $display("FAIL reset_ctrl dut%0d: got %b required 00111", d, {busy[d], done[d], cs[d], we[d], re[d]}); end
         checks++;
         if (addr[d] !== 0 || wd[d] !== 0 || ciph[d] !== 0) begin failures++; $display("FAIL reset_data dut%0d: addr=%h wd=%h cipher=%h required 0", d, addr[d], wd[d], ciph[d]); end
      end
      rst = 0;
   endtask

   task automatic test_fips_c1;
      int lat;
      logic [255:0] kp;
      kp = {C1K, C1P};
      start_op(0, C1K, C1P);
      wait_done(0, lat);
      checks++;
      if (lat != 37) begin failures++; $display("FAIL c1_latency: got %0d required 37", lat); end
      checks++;
      if (ciph[0] !== C1C) begin failures++; $display("FAIL c1_cipher: got %h required %h", ciph[0], C1C); end
      checks++;
      if (wq.size() != 8) begin failures++; $display("FAIL c1_write_count: got %0d required 8", wq.size()); end
      for (int i = 0; i < 8 && i < wq.size(); i++) begin
         checks++;
         if (wq[i] !== {4'(i), 32'(kp >> (32 * (7 - i)))}) begin failures++; $display("FAIL c1_write%0d: got %h required %h", i, wq[i], {4'(i), 32'(kp >> (32 * (7 - i)))}); end
      end
      trace1 = wq;
   endtask

   task automatic test_back_to_back;
      int lat, prev;
      prev = done_edge;
      checks++;
      if (busy[0] !== 0 || done[0] !== 1) begin failures++; $display("FAIL b2b_done_cycle: busy=%b done=%b required 0/1", busy[0], done[0]); end
      start_op(0, BK, BP);
      checks++;
      if (s_edge != prev + 1 || busy[0] !== 1) begin failures++; $display("FAIL b2b_gap: start edge %0d busy=%b required edge %0d busy 1", s_edge, busy[0], prev + 1); end
      wait_done(0, lat);
      checks++;
      if (lat != 37) begin failures++; $display("FAIL b2b_latency: got %0d required 37", lat); end
      checks++;
      if (ciph[0] !== BC) begin failures++; $display("FAIL b2b_cipher: got %h required %h", ciph[0], BC); end
   endtask

   task automatic test_ignore_start;
      int lat, n;
      bit same;
      start_op(0, C1K, C1P);
      repeat (12) @(negedge clk);
      st[0] = 1;
      @(negedge clk);
      st[0] = 0;
      repeat (19) @(negedge clk);
      st[0] = 1;
      @(negedge clk);
      st[0] = 0;
      wait_done(0, lat);
      checks++;
      if (lat != 37) begin failures++; $display("FAIL ign_latency: got %0d required 37", lat); end
      checks++;
      if (ciph[0] !== C1C) begin failures++; $display("FAIL ign_cipher: got %h required %h", ciph[0], C1C); end
      same = wq.size() == trace1.size();
      for (int i = 0; same && i < wq.size(); i++) same = wq[i] === trace1[i];
      checks++;
      if (!same) begin failures++; $display("FAIL ign_trace: got %0d writes differing from reference trace of %0d", wq.size(), trace1.size()); end
      n = 0;
      repeat (50) begin @(negedge clk); if (done[0]) n++; end
      checks++;
      if (n != 0 || busy[0] !== 0) begin failures++; $display("FAIL ign_extra_done: got %0d extra done busy=%b required 0/0", n, busy[0]); end
   endtask

   task automatic test_reset_mid_op;
      int lat, n;
      start_op(0, C1K, C1P);
      repeat (6) @(negedge clk);
      checks++;
      if (cs[0] !== 0 || we[0] !== 0 || addr[0] !== 4'd5) begin failures++; $display("FAIL mid_write: cs=%b we=%b addr=%h required 0/0/5", cs[0], we[0], addr[0]); end
      #1 rst = 1;
      #1;
      checks++;
      if ({cs[0], we[0], re[0], busy[0], done[0]} !== 5'b11100 || addr[0] !== 0 || wd[0] !== 0) begin failures++; $display("FAIL mid_reset_bus: ctrl=%b addr=%h wd=%h required 11100/0/0", {cs[0], we[0], re[0], busy[0], done[0]}, addr[0], wd[0]); end
      checks++;
      if (ciph[0] !== 0) begin failures++; $display("FAIL mid_reset_cipher: got %h required 0", ciph[0]); end
      @(negedge clk);
      rst = 0;
      n = 0;
      repeat (50) begin @(negedge clk); if (done[0]) n++; end
      checks++;
      if (n != 0) begin failures++; $display("FAIL mid_reset_done: got %0d done pulses required 0", n); end
      start_op(0, C1K, C1P);
      wait_done(0, lat);
      checks++;
      if (lat != 37 || ciph[0] !== C1C) begin failures++; $display("FAIL mid_reset_rerun: lat=%0d cipher=%h required 37 %h", lat, ciph[0], C1C); end
   endtask

   task automatic test_random;
      logic [127:0] k, p, prev;
      int lat;
      for (int i = 0; i < 4; i++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         p = {$urandom, $urandom, $urandom, $urandom};
         prev = ciph[0];
         repeat ($urandom_range(0, 3)) @(negedge clk);
         start_op(0, k, p);
         repeat (10) @(negedge clk);
         checks++;
         if (ciph[0] !== prev) begin failures++; $display("FAIL rnd_hold%0d: got %h required %h", i, ciph[0], prev); end
         wait_done(0, lat);
         checks++;
         if (lat != 37) begin failures++; $display("FAIL rnd_latency%0d: got %0d required 37", i, lat); end
         checks++;
         if (ciph[0] !== aes_ref(k, p)) begin failures++; $display("FAIL rnd_cipher%0d: got %h required %h", i, ciph[0], aes_ref(k, p)); end
      end
   endtask

   task automatic test_slow_read;
      logic [127:0] k, p;
      int lat;
      for (int i = 0; i < 3; i++) begin
         k = i == 0 ? C1K : {$urandom, $urandom, $urandom, $urandom};
         p = i == 0 ? C1P : {$urandom, $urandom, $urandom, $urandom};
         start_op(1, k, p);
         wait_done(1, lat);
         checks++;
         if (lat != 44) begin failures++; $display("FAIL slow_latency%0d: got %0d required 44", i, lat); end
         checks++;
         if (ciph[1] !== aes_ref(k, p)) begin failures++; $display("FAIL slow_cipher%0d: got %h required %h", i, ciph[1], aes_ref(k, p)); end
         checks++;
         if (!(rc.size() == 4 && rc[3] - rc[0] == 3)) begin failures++; $display("FAIL slow_reads%0d: got %0d reads not consecutive, required 4 consecutive", i, rc.size()); end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin st[d] = 0; key[d] = 0; pl[d] = 0; end
      test_reset;
      test_fips_c1;
      test_back_to_back;
      test_ignore_start;
      test_reset_mid_op;
      test_random;
      test_slow_read;
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/aes_bus_master.md
Name: aes_bus_master

Overview:
- Bus initiator that drives the AES-128 memory-mapped peripheral.
- Accepts a 128-bit key and plaintext from local logic.
- Writes the key and plaintext as eight 32-bit words, waits a fixed number of cycles for the encryption to finish, then reads back the four ciphertext words.
- Presents the 128-bit ciphertext with a one-cycle done pulse. It sits between the control/datapath logic and the peripheral's chip-select/write/read/address/data port.

Parameters:
- WAIT_CYCLES, 24, idle cycles between the last write and the first read; must cover the peripheral's encrypt latency; legal range 1..255.
- READ_LATENCY, 1, clock edges from a read issue to valid iRdData; legal values 1 or 2.

Ports:
- iClk  in  1  system clock; all logic on the rising edge
- iReset  in  1  asynchronous, active-high reset
- iStart  in  1  request; sampled only in IDLE
- iKey  in  128  key; bits [127:96] are word 0
- iPlain  in  128  plaintext; bits [127:96] are word 0
- oBusy  out  1  high in every state except IDLE
- oDone  out  1  one-cycle pulse when oCipher is valid
- oCipher  out  128  ciphertext; holds its value until the next oDone
- oChipselect_n  out  1  bus chip select, active low
- oWrite_n  out  1  bus write strobe, active low
- oRead_n  out  1  bus read strobe, active low
- oAddress  out  4  bus word address
- oWrData  out  32  bus write data
- iRdData  in  32  bus read data from the peripheral

Behaviour:
- Reset (asynchronous, immediate, valid mid-operation):
  - State goes to IDLE.
  - oChipselect_n, oWrite_n and oRead_n go to 1.
  - oAddress, oWrData, oCipher and all counters go to 0.
  - oBusy and oDone go to 0.
  - Any transfer in flight is abandoned; no partial oDone.
- All bus outputs are registered. Outside the WRITE and READ issue cycles the strobes are 1, and oAddress and oWrData are 0.
- States: IDLE -> WRITE -> WAIT -> READ -> IDLE.
- IDLE:
  - On the edge where iStart=1, latch iKey and iPlain into internal registers and go to WRITE.
  - iStart is ignored in every other state; there is no queueing.
- WRITE: 8 consecutive cycles, one word per cycle, with oChipselect_n=0 and oWrite_n=0.
  - Addresses 0..3 carry key words [127:96], [95:64], [63:32], [31:0].
  - Addresses 4..7 carry plaintext words in the same order.
  - Address 7 is always written last, because the peripheral starts the encryption on that write.
  - After the address 7 cycle, go to WAIT.
- WAIT: exactly WAIT_CYCLES cycles with strobes at 1, then go to READ.
- READ:
  - Issue phase: addresses 8, 9, 10, 11 on 4 consecutive cycles, with oChipselect_n=0 and oRead_n=0.
  - Capture phase: the word issued at edge E is sampled from iRdData at edge E+READ_LATENCY and stored in oCipher slice [127:96], [95:64], [63:32], [31:0] respectively.
  - On the edge that captures address 11: update oCipher, set oDone=1 for one cycle, and return to IDLE. oBusy falls in that same cycle.
- Latency: oDone rises 8 + WAIT_CYCLES + 4 + READ_LATENCY edges after the edge that samples iStart. With default parameters that is 37 edges.
- Back-to-back operation: if iStart=1 in the cycle where oDone=1, it is accepted (state is IDLE), so a new operation starts without a gap.
- oCipher changes only on the edge that asserts oDone. All four words update together; no partial update is visible.
- iKey and iPlain may change after acceptance without affecting the operation in flight.

Test Plan:
1. FIPS-197 App. C.1 against a bus-accurate peripheral model: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> write sequence addr 0..7 = 00010203, 04050607, 08090a0b, 0c0d0e0f, 00112233, 44556677, 8899aabb, ccddeeff; oDone 37 edges after start; oCipher = 69c4e0d86a7b0430d8cdb78070b4c55a.
2. FIPS-197 App. B, back-to-back with test 1 (iStart held during oDone): key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> second operation starts without a gap; oCipher = 3925841d02dc09fbdc118597196a0b32.
3. Pulse iStart at WAIT cycle 5 and again during READ -> pulses ignored; exactly one oDone; bus trace identical to test 1.
4. Assert iReset during WRITE at address 5 -> strobes go to 1 immediately; oBusy=0; no oDone. A subsequent start completes test 1 correctly.
5. READ_LATENCY=2 and WAIT_CYCLES=30 with a 2-cycle model -> reads at addresses 8..11 are consecutive; oDone 44 edges after start; correct ciphertext.
6. Protocol checker on every run:
   - oWrite_n and oRead_n are never both 0.
   - Neither strobe is 0 while oChipselect_n=1.
   - Exactly 8 writes and 4 reads per operation.
   - oDone is never 2 cycles wide.
